ready_bits_event_queue: RTL and testbench

Retire-event serializer that feeds the issue stage's ready-bits demux. Collects GPR ready-bit release events from the ALU and LSU retire paths, which may both fire in the same cycle. Buffers them in a small in-order FIFO and emits at most one event per cycle as a (bits, wfid, en) triple that drives the demux's `in`/`addr`/`en` inputs.

---
 rtl/ready_bits_event_queue.sv | 134 +++++++++++++
 tb/tb_ready_bits_event_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ready_bits_event_queue.sv
// Retire-event serializer for the issue stage's ready-bits demux.
// ALU and LSU retire events enter a small in-order FIFO, and at most one
// event per cycle leaves it as a (bits, wfid, en) triple.

`ifndef ISSUE_GPR_RD_BITS_LENGTH
`define ISSUE_GPR_RD_BITS_LENGTH 8
`endif
`ifndef WF_ID_LENGTH
`define WF_ID_LENGTH 6
`endif
`ifndef WF_PER_CU
`define WF_PER_CU 40
`endif

module ready_bits_event_queue #(
    parameter int TOTAL_INFO_LENGTH = `ISSUE_GPR_RD_BITS_LENGTH,
    parameter int DEPTH             = 8,
    parameter int CNT_W             = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alu_valid,
    input  logic [`WF_ID_LENGTH-1:0]     alu_wfid,
    input  logic [TOTAL_INFO_LENGTH-1:0] alu_bits,
    output logic                         alu_ready,
    input  logic                         lsu_valid,
    input  logic [`WF_ID_LENGTH-1:0]     lsu_wfid,
    input  logic [TOTAL_INFO_LENGTH-1:0] lsu_bits,
    output logic                         lsu_ready,
    input  logic                         hold,
    output logic [TOTAL_INFO_LENGTH-1:0] out_bits,
    output logic [`WF_ID_LENGTH-1:0]     out_wfid,
    output logic                         out_en,
    output logic [CNT_W-1:0]             occupancy,
    output logic                         err_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int IDW   = `WF_ID_LENGTH;
    localparam logic [IDW-1:0] WF_LIMIT = IDW'(`WF_PER_CU);

    logic [TOTAL_INFO_LENGTH-1:0] r_memBits [DEPTH];
    logic [IDW-1:0]               r_memWfid [DEPTH];
    logic [PTR_W-1:0]             r_wp;
    logic [PTR_W-1:0]             r_rp;
    logic [CNT_W-1:0]             r_cnt;
    logic [TOTAL_INFO_LENGTH-1:0] r_outBits;
    logic [IDW-1:0]               r_outWfid;
    logic                         r_outEn;
    logic                         r_errDrop;

    logic                         w_aluReady;
    logic                         w_lsuReady;
    logic                         w_aluAcc;
    logic                         w_lsuAcc;
    logic                         w_aluDrop;
    logic                         w_lsuDrop;
    logic                         w_pop;
    logic [CNT_W-1:0]             w_pushCnt;
    logic [PTR_W-1:0]             w_lsuPtr;

    // Readiness, accept/drop decisions, pop decision and LSU slot selection
    always_comb begin
        w_aluReady = (r_cnt <= CNT_W'(DEPTH - 1));
        w_lsuReady = (r_cnt <= CNT_W'(DEPTH - 2));
        w_aluAcc   = alu_valid && w_aluReady && (alu_wfid < WF_LIMIT);
        w_lsuAcc   = lsu_valid && w_lsuReady && (lsu_wfid < WF_LIMIT);
        w_aluDrop  = alu_valid && (!w_aluReady || (alu_wfid >= WF_LIMIT));
        w_lsuDrop  = lsu_valid && (!w_lsuReady || (lsu_wfid >= WF_LIMIT));
        w_pop      = (r_cnt != '0) && !hold;
        w_pushCnt  = CNT_W'(w_aluAcc) + CNT_W'(w_lsuAcc);
        w_lsuPtr   = w_aluAcc ? (r_wp + PTR_W'(1)) : r_wp;
    end

    // FIFO storage writes; ALU always takes the slot ahead of LSU
    always_ff @(posedge clk) begin
        if (w_aluAcc) begin
            r_memBits[r_wp] <= alu_bits;
            r_memWfid[r_wp] <= alu_wfid;
        end
        if (w_lsuAcc) begin
            r_memBits[w_lsuPtr] <= lsu_bits;
            r_memWfid[w_lsuPtr] <= lsu_wfid;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            r_wp  <= r_wp + PTR_W'(w_pushCnt);
            r_rp  <= r_rp + PTR_W'(w_pop);
            r_cnt <= r_cnt + w_pushCnt - CNT_W'(w_pop);
        end
    end

    // Registered output triple; zeroed whenever no entry is popped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outEn   <= 1'b0;
            r_outBits <= '0;
            r_outWfid <= '0;
        end else if (w_pop) begin
            r_outEn   <= 1'b1;
            r_outBits <= r_memBits[r_rp];
            r_outWfid <= r_memWfid[r_rp];
        end else begin
            r_outEn   <= 1'b0;
            r_outBits <= '0;
            r_outWfid <= '0;
        end
    end

    // Sticky protocol-error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_errDrop <= 1'b0;
        end else if (w_aluDrop || w_lsuDrop) begin
            r_errDrop <= 1'b1;
        end
    end

    assign alu_ready = w_aluReady;
    assign lsu_ready = w_lsuReady;
    assign out_bits  = r_outBits;
    assign out_wfid  = r_outWfid;
    assign out_en    = r_outEn;
    assign occupancy = r_cnt;
    assign err_drop  = r_errDrop;

endmodule

// File: tb/tb_ready_bits_event_queue.sv
// Scoreboard bench for ready_bits_event_queue: a queue-based reference model
// predicts every strobe, and a separate monitor compares what the DUT emits.

`ifndef ISSUE_GPR_RD_BITS_LENGTH
`define ISSUE_GPR_RD_BITS_LENGTH 8
`endif
`ifndef WF_ID_LENGTH
`define WF_ID_LENGTH 6
`endif
`ifndef WF_PER_CU
`define WF_PER_CU 40
`endif

module tb_ready_bits_event_queue;

    localparam int BW    = 8;
    localparam int IW    = `WF_ID_LENGTH;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int WFMAX = `WF_PER_CU;

    typedef struct {
        logic [BW-1:0] bits;
        logic [IW-1:0] wfid;
    } ev_t;

    logic          clk;
    logic          rst_n;
    logic          alu_valid;
    logic [IW-1:0] alu_wfid;
    logic [BW-1:0] alu_bits;
    logic          alu_ready;
    logic          lsu_valid;
    logic [IW-1:0] lsu_wfid;
    logic [BW-1:0] lsu_bits;
    logic          lsu_ready;
    logic          hold;
    logic [BW-1:0] out_bits;
    logic [IW-1:0] out_wfid;
    logic          out_en;
    logic [CNT_W-1:0] occupancy;
    logic          err_drop;

    ev_t modelQ[$];
    ev_t expQ[$];
    logic mErr;
    logic monOn;
    int   checks;
    int   errors;

    ready_bits_event_queue #(
        .TOTAL_INFO_LENGTH(BW),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .alu_valid(alu_valid),
        .alu_wfid(alu_wfid),
        .alu_bits(alu_bits),
        .alu_ready(alu_ready),
        .lsu_valid(lsu_valid),
        .lsu_wfid(lsu_wfid),
        .lsu_bits(lsu_bits),
        .lsu_ready(lsu_ready),
        .hold(hold),
        .out_bits(out_bits),
        .out_wfid(out_wfid),
        .out_en(out_en),
        .occupancy(occupancy),
        .err_drop(err_drop)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle: check pre-edge state against the model, drive inputs,
    // advance the model across the coming edge, then return at the next negedge.
    task automatic applyStimulus(input logic av, input logic [IW-1:0] aw, input logic [BW-1:0] ab,
                                 input logic lv, input logic [IW-1:0] lw, input logic [BW-1:0] lb,
                                 input logic hd, input logic rn);
        int  n;
        bit  aluR;
        bit  lsuR;
        ev_t e;
        n    = modelQ.size();
        aluR = (n <= DEPTH - 1);
        lsuR = (n <= DEPTH - 2);
        if (monOn) begin
            checkOutput("occupancy", int'(occupancy), n);
            checkOutput("alu_ready", int'(alu_ready), int'(aluR));
            checkOutput("lsu_ready", int'(lsu_ready), int'(lsuR));
            checkOutput("err_drop", int'(err_drop), int'(mErr));
        end
        alu_valid = av; alu_wfid = aw; alu_bits = ab;
        lsu_valid = lv; lsu_wfid = lw; lsu_bits = lb;
        hold = hd; rst_n = rn;
        if (!rn) begin
            modelQ.delete();
            mErr = 1'b0;
        end else begin
            if (!hd && n > 0) expQ.push_back(modelQ.pop_front());
            if (av) begin
                if (aluR && int'(aw) < WFMAX) begin
                    e.bits = ab; e.wfid = aw;
                    modelQ.push_back(e);
                end else begin
                    mErr = 1'b1;
                end
            end
            if (lv) begin
                if (lsuR && int'(lw) < WFMAX) begin
                    e.bits = lb; e.wfid = lw;
                    modelQ.push_back(e);
                end else begin
                    mErr = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic hd);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, hd, 1'b1);
    endtask

    // Monitor: every strobe must match the oldest predicted event; idle cycles must show zeros
    always @(negedge clk) begin
        if (monOn) begin
            if (out_en === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_strobe", 1, 0);
                end else begin
                    ev_t e;
                    e = expQ.pop_front();
                    checkOutput("out_wfid", int'(out_wfid), int'(e.wfid));
                    checkOutput("out_bits", int'(out_bits), int'(e.bits));
                end
            end else begin
                checkOutput("out_en_known", int'(out_en === 1'b0), 1);
                checkOutput("idle_bits_zero", int'(out_bits), 0);
                checkOutput("idle_wfid_zero", int'(out_wfid), 0);
            end
        end
    end

    initial begin
        checks = 0; errors = 0; mErr = 1'b0; monOn = 1'b0;
        alu_valid = 0; alu_wfid = '0; alu_bits = '0;
        lsu_valid = 0; lsu_wfid = '0; lsu_bits = '0;
        hold = 0; rst_n = 0;
        @(negedge clk);
        applyStimulus(0, '0, '0, 0, '0, '0, 0, 1'b0);
        monOn = 1'b1;
        applyStimulus(0, '0, '0, 0, '0, '0, 0, 1'b0);

        // Single event: wfid 5, bits 0x3
        applyStimulus(1, IW'(5), BW'(8'h03), 0, '0, '0, 0, 1);
        repeat (3) idle(0);

        // Simultaneous ALU and LSU push
        applyStimulus(1, IW'(1), BW'(8'h11), 1, IW'(2), BW'(8'h22), 0, 1);
        repeat (4) idle(0);

        // Fill under hold, overflow ALU push, then drain
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1, IW'(10 + i), BW'(8'hA0 + i), 0, '0, '0, 1, 1);
        applyStimulus(1, IW'(3), BW'(8'hEE), 1, IW'(4), BW'(8'hEF), 1, 1);
        repeat (DEPTH + 3) idle(0);

        // Invalid wfid after a reset clears the sticky flag
        applyStimulus(0, '0, '0, 0, '0, '0, 0, 1'b0);
        applyStimulus(1, IW'(40), BW'(8'h55), 0, '0, '0, 0, 1);
        repeat (3) idle(0);
        applyStimulus(0, '0, '0, 1, IW'(39), BW'(8'h66), 0, 1);
        repeat (3) idle(0);

        // Hold bubbles
        applyStimulus(1, IW'(7), BW'(8'h71), 1, IW'(8), BW'(8'h72), 1, 1);
        applyStimulus(1, IW'(9), BW'(8'h73), 0, '0, '0, 1, 1);
        idle(1); idle(0); idle(1); idle(0); idle(0);
        repeat (2) idle(0);

        // Reset mid-operation with 5 queued entries
        for (int i = 0; i < 5; i++)
            applyStimulus(1, IW'(20 + i), BW'(8'hC0 + i), 0, '0, '0, 1, 1);
        applyStimulus(0, '0, '0, 0, '0, '0, 0, 1'b0);
        repeat (4) idle(0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            logic av, lv, hd, rn;
            av = ($urandom_range(0, 99) < 55);
            lv = ($urandom_range(0, 99) < 45);
            hd = ($urandom_range(0, 99) < 35);
            rn = ($urandom_range(0, 199) != 0);
            applyStimulus(av, IW'($urandom_range(0, 42)), BW'($urandom),
                          lv, IW'($urandom_range(0, 42)), BW'($urandom), hd, rn);
        end

        repeat (DEPTH + 4) idle(0);
        checkOutput("drain_empty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
